letc_core_limp_arbiter: RTL and testbench

LETC_CORE_LIMP_ARBITER -- requirements
Module: letc_core_limp_arbiter

---
 rtl/letc_core_pkg.sv | 21 ++
 rtl/letc_core_rr_picker.sv | 29 ++
 rtl/letc_core_limp_arbiter.sv | 104 ++++++++++
 tb/tb_letc_core_limp_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/letc_core_pkg.sv
// Shared LETC core types: LIMP access sizes, requester indices and arbiter states.
// Imported by every LIMP-facing block.
package letc_core_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALFWORD = 2'b01,
    SIZE_WORD     = 2'b10
  } size_e;

  localparam int NUM_LIMP_REQ = 3;
  localparam int LIMP_REQ_L1I = 0;
  localparam int LIMP_REQ_L1D = 1;
  localparam int LIMP_REQ_MMU = 2;

  typedef enum logic {
    LIMP_ARB_IDLE,
    LIMP_ARB_BUSY
  } limp_arb_state_e;

endpackage

// File: rtl/letc_core_rr_picker.sv
// Round-robin picker: one-hot choice of the first set request after last_grant.
// Purely combinational; returns all-zero when no request is set.
module letc_core_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] pick
);

  int               idx;
  logic [IDX_W-1:0] idx_w;

  // Scan starts one past the previous owner and wraps, so the previous owner is checked last.
  always_comb begin
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx   = (int'(last_grant) + off) % NUM_REQ;
      idx_w = IDX_W'(idx);
      if (req[idx_w] && (pick == '0)) begin
        pick[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/letc_core_limp_arbiter.sv
// Round-robin arbiter muxing NUM_REQ LIMP requesters onto one downstream LIMP port.
// One arbitration cycle then BUSY until i_mem_ready; the grant is held for the whole transaction.
module letc_core_limp_arbiter
  import letc_core_pkg::*;
#(
  parameter int NUM_REQ = NUM_LIMP_REQ
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ-1:0]        i_req_wen_nren,
  input  size_e [NUM_REQ-1:0]       i_req_size,
  input  logic [NUM_REQ-1:0][31:0]  i_req_addr,
  input  logic [NUM_REQ-1:0][31:0]  i_req_wdata,
  output logic [31:0]               o_req_rdata,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_mem_valid,
  input  logic                      i_mem_ready,
  output logic                      o_mem_wen_nren,
  output size_e                     o_mem_size,
  output logic [31:0]               o_mem_addr,
  output logic [31:0]               o_mem_wdata,
  input  logic [31:0]               i_mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  limp_arb_state_e      state;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 busy;
  logic                 mem_done;

  letc_core_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .pick       (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Reset gates the outputs directly so nothing leaks while i_rst is held.
  assign busy     = (state == LIMP_ARB_BUSY) && !i_rst;
  assign mem_done = o_mem_valid && i_mem_ready;

  assign o_mem_valid    = busy && i_req_valid[grant_idx];
  assign o_mem_wen_nren = busy && i_req_wen_nren[grant_idx];
  assign o_mem_size     = busy ? i_req_size[grant_idx] : SIZE_BYTE;
  assign o_mem_addr     = busy ? i_req_addr[grant_idx]  : 32'h0;
  assign o_mem_wdata    = busy ? i_req_wdata[grant_idx] : 32'h0;
  assign o_req_ready    = mem_done ? grant : '0;
  assign o_req_rdata    = i_mem_rdata;
  assign o_grant        = i_rst ? '0 : grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= LIMP_ARB_IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        LIMP_ARB_IDLE: begin
          if (|i_req_valid) begin
            grant     <= pick;
            grant_idx <= pick_idx;
            state     <= LIMP_ARB_BUSY;
          end
        end
        LIMP_ARB_BUSY: begin
          if (mem_done) begin
            last_grant <= grant_idx;
            grant      <= '0;
            state      <= LIMP_ARB_IDLE;
          end else if (!o_mem_valid) begin
            // Owner withdrew mid-transaction: drop it without advancing the rotation.
            grant <= '0;
            state <= LIMP_ARB_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= LIMP_ARB_IDLE;
        end
      endcase
    end
  end

  owner_holds_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    (state == LIMP_ARB_BUSY) |-> i_req_valid[grant_idx]);

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Bench for letc_core_limp_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level round-robin model.
module tb_letc_core_limp_arbiter;
  import letc_core_pkg::*;

  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        req_wen;
  size_e [N-1:0]       req_size;
  logic [N-1:0][31:0]  req_addr;
  logic [N-1:0][31:0]  req_wdata;
  logic [31:0]         req_rdata;
  logic [N-1:0]        grant;
  logic                mem_valid;
  logic                mem_ready;
  logic                mem_wen;
  size_e               mem_size;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int m_owner = -1;
  int m_last  = N - 1;
  int m_done  = -1;

  always #5 clk = ~clk;

  letc_core_limp_arbiter #(.NUM_REQ(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wen_nren (req_wen),
    .i_req_size     (req_size),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_req_rdata    (req_rdata),
    .o_grant        (grant),
    .o_mem_valid    (mem_valid),
    .i_mem_ready    (mem_ready),
    .o_mem_wen_nren (mem_wen),
    .o_mem_size     (mem_size),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Priority list: previous owner + 1, + 2, ... wrapping; first valid entry wins.
  function automatic int rr_choose(input logic [N-1:0] v, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_update();
    m_done = -1;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      if (req_valid != '0) m_owner = rr_choose(req_valid, m_last);
    end else if (req_valid[m_owner] && mem_ready) begin
      m_done  = m_owner;
      m_last  = m_owner;
      m_owner = -1;
    end else if (!req_valid[m_owner]) begin
      m_owner = -1;
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    logic         emv;
    eg  = '0;
    emv = 1'b0;
    if (!rst && m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      emv = req_valid[m_owner];
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("mem_valid", 32'(mem_valid), 32'(emv));
    chk("req_ready", 32'(req_ready), (emv && mem_ready) ? 32'(eg) : 32'h0);
    chk("req_rdata", req_rdata, mem_rdata);
    if (emv) begin
      chk("mem_wen", 32'(mem_wen), 32'(req_wen[m_owner]));
      chk("mem_size", 32'(mem_size), 32'(req_size[m_owner]));
      chk("mem_addr", mem_addr, req_addr[m_owner]);
      chk("mem_wdata", mem_wdata, req_wdata[m_owner]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_wen[i]   = 1'($urandom_range(0, 1));
    req_size[i]  = size_e'($urandom_range(0, 2));
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 0, 1};

    rst = 1'b1; req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) req_size[i] = SIZE_BYTE;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    cycle(); cycle();
    settle();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    rst = 1'b0;
    cycle();

    // Stray memory ready while idle.
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    cycle();
    settle();
    chk("idle_ready_ignored", 32'(req_ready), 32'h0);
    chk("idle_grant", 32'(grant), 32'h0);
    mem_ready = 1'b0;

    // Single read from requester 0, memory answers on the third BUSY cycle.
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_size[0] = SIZE_WORD; req_addr[0] = 32'h8000_0000;
    settle();
    chk("rd_arb_grant", 32'(grant), 32'h0);
    cycle();
    settle();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_addr", mem_addr, 32'h8000_0000);
    cycle(); cycle();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_rdata", req_rdata, 32'hDEAD_BEEF);
    cycle();
    req_valid[0] = 1'b0; mem_ready = 1'b0;
    settle();
    chk("rd_done_grant", 32'(grant), 32'h0);

    // All three continuously valid after reset: strict rotation.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 3'b111; mem_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cycle();
      settle();
      chk("rot_grant", 32'(grant), 32'(1) << order[t]);
      chk("rot_ready", 32'(req_ready), 32'(1) << order[t]);
      cycle();
      settle();
      chk("rot_gap", 32'(grant), 32'h0);
    end

    // Write from requester 1 while requester 2 shows up mid-transaction.
    req_valid = 3'b010; mem_ready = 1'b0;
    req_wen[1] = 1'b1; req_size[1] = SIZE_WORD; req_addr[1] = 32'h0000_1004; req_wdata[1] = 32'h1234_5678;
    cycle();
    req_valid[2] = 1'b1;
    settle();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_addr", mem_addr, 32'h0000_1004);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_wen", 32'(mem_wen), 32'h1);
    chk("wr_size", 32'(mem_size), 32'(SIZE_WORD));
    cycle();
    settle();
    chk("wr_hold_grant", 32'(grant), 32'h2);
    mem_ready = 1'b1;
    settle();
    chk("wr_ready", 32'(req_ready), 32'h2);
    cycle();
    req_valid[1] = 1'b0; mem_ready = 1'b0;
    settle();
    chk("wr_idle", 32'(grant), 32'h0);
    cycle();
    settle();
    chk("pend_grant2", 32'(grant), 32'h4);
    mem_ready = 1'b1;
    cycle();
    req_valid[2] = 1'b0; mem_ready = 1'b0;

    // Reset in the second BUSY cycle, then requester 0 beats requester 2.
    req_valid = 3'b010;
    cycle(); cycle();
    rst = 1'b1;
    settle();
    chk("rst_busy_grant", 32'(grant), 32'h0);
    chk("rst_busy_valid", 32'(mem_valid), 32'h0);
    cycle();
    rst = 1'b0; req_valid = 3'b101;
    settle();
    chk("post_rst_grant", 32'(grant), 32'h0);
    cycle();
    settle();
    chk("post_rst_first", 32'(grant), 32'h1);
    mem_ready = 1'b1;
    cycle();
    req_valid[0] = 1'b0; mem_ready = 1'b0;
    cycle();
    mem_ready = 1'b1;
    cycle();
    req_valid = '0; mem_ready = 1'b0;
    cycle();

    // Requester 2 alone, back to back.
    req_valid = 3'b100; mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cycle();
      settle();
      chk("solo2_grant", 32'(grant), 32'h4);
      chk("solo2_ready", 32'(req_ready), 32'h4);
      cycle();
      settle();
      chk("solo2_gap", 32'(grant), 32'h0);
    end
    req_valid = '0; mem_ready = 1'b0;

    // Randomized traffic; requesters hold each request until served.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (m_done == i) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else new_req(i);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
